// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_Idle,
    S_Start,
    S_Data,
    S_Parity,
    S_Stop
  } rx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic PARITY_EVEN = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  // Parity bit the transmitter is expected to send for a given byte.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ ~PARITY_EVEN;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the serial line plus a registered
// falling-edge flag aligned with the synchronised output.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   fall_q, fall_d;

  // Shift the line through the chain; the flag fires in the same cycle the
  // last stage first shows 0 after having shown 1.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    fall_d = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
  end

  // Chain resets to the idle level so reset release never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fall_q <= fall_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign fall = fall_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Mid-bit sampling FSM feeding a one-deep holding register with
// valid/read handshake, parity/framing status and sticky overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Serial_In,
  input  logic                 Data_Read,
  output logic [DATA_BITS-1:0] Dout,
  output logic                 Data_Valid,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Overrun,
  output logic                 RBusy
);

  localparam int             CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     LAST_IDX = 3'(DATA_BITS - 1);

  logic rx, rx_fall;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (Clk),
    .rst_n(Rst),
    .din  (Serial_In),
    .dout (rx),
    .fall (rx_fall)
  );

  rx_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;
  logic                   tick;

  logic [DATA_BITS-1:0]   dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   ovr_q, ovr_d;

  // Start bit is checked after half a period; every later bit after a full one.
  always_comb begin
    tick = (state_q == S_Start) ? (cnt_q == HALF_TC) : (cnt_q == FULL_TC);
  end

  // Frame FSM: next state, baud counter, bit index, shift register, status.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    case (state_q)
      S_Idle: begin
        cnt_d = '0;
        if (rx_fall) state_d = S_Start;
      end
      S_Start: begin
        if (tick) begin
          cnt_d = '0;
          idx_d = '0;
          // A line back high at mid-start was a glitch: drop silently.
          state_d = rx ? S_Idle : S_Data;
        end
      end
      S_Data: begin
        if (tick) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx;
          idx_d          = idx_q + 3'd1;
          if (idx_q == LAST_IDX) state_d = S_Parity;
        end
      end
      S_Parity: begin
        if (tick) begin
          cnt_d   = '0;
          perr_d  = parity_bit(shift_q) ^ rx;
          state_d = S_Stop;
        end
      end
      S_Stop: begin
        if (tick) begin
          cnt_d   = '0;
          ferr_d  = ~rx;
          done_d  = 1'b1;
          // Re-arm at mid-stop so a directly following start edge is caught.
          state_d = S_Idle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_Idle;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_Idle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // Holding register: load a finished frame if the slot is free or being
  // read this cycle, otherwise drop it and flag overrun.
  always_comb begin
    dout_d    = dout_q;
    valid_d   = valid_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    ovr_d     = ovr_q;
    if (done_q) begin
      if (!valid_q || Data_Read) begin
        dout_d    = shift_q;
        par_err_d = perr_q;
        frm_err_d = ferr_q;
        valid_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (Data_Read && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      dout_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign Dout       = dout_q;
  assign Data_Valid = valid_q;
  assign Parity_Err = par_err_q;
  assign Frame_Err  = frm_err_q;
  assign Overrun    = ovr_q;
  assign RBusy      = (state_q != S_Idle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// compared against a byte-level model of the receive holding register.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int SS  = 2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Serial_In = 1'b1;
  logic       Data_Read = 1'b0;
  logic [7:0] Dout;
  logic       Data_Valid, Parity_Err, Frame_Err, Overrun, RBusy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = -1;

  // Model of what the consumer should see: held byte, status, valid, overrun.
  logic       m_valid = 1'b0;
  logic [7:0] m_dout  = 8'h00;
  logic       m_perr  = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SS)) dut (
    .Clk(Clk), .Rst(Rst), .Serial_In(Serial_In), .Data_Read(Data_Read),
    .Dout(Dout), .Data_Valid(Data_Valid), .Parity_Err(Parity_Err),
    .Frame_Err(Frame_Err), .Overrun(Overrun), .RBusy(RBusy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles elapsed", cyc);
    $fatal(1);
  end

  function automatic logic [11:0] obs();
    return {Data_Valid, Dout, Parity_Err, Frame_Err, Overrun};
  endfunction

  function automatic logic [11:0] mexp();
    return {m_valid, m_dout, m_perr, m_ferr, m_ovr};
  endfunction

  task automatic mdl_reset();
    m_valid = 1'b0; m_dout = 8'h00; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  // A completed frame: even parity means the parity bit equals XOR of data.
  task automatic mdl_frame(input logic [7:0] d, input logic p, input logic s, input logic rd);
    if (!m_valid || rd) begin
      m_dout  = d;
      m_perr  = ((^d) != p);
      m_ferr  = !s;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic mdl_read();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    Serial_In = b;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic read_pulse();
    Data_Read = 1'b1;
    idle(1);
    Data_Read = 1'b0;
    mdl_read();
  endtask

  task automatic test_reset();
    idle(3);
    n_tests++;
    if ({obs(), RBusy} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", {obs(), RBusy});
    end
    Rst = 1'b1;
    idle(4);
    n_tests++;
    if ({obs(), RBusy} !== 13'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h, expected 0", {obs(), RBusy});
    end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b0, 1'b1);
    mdl_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(2);
    n_tests++;
    if (obs() !== mexp()) begin
      n_fail++;
      $display("FAIL basic_a5: got %h, expected %h", obs(), mexp());
    end
    read_pulse();
    n_tests++;
    if ({obs(), RBusy} !== {mexp(), 1'b0}) begin
      n_fail++;
      $display("FAIL basic_read: got %h, expected %h", {obs(), RBusy}, {mexp(), 1'b0});
    end
  endtask

  task automatic test_parity();
    send_frame(8'h01, 1'b0, 1'b1);
    mdl_frame(8'h01, 1'b0, 1'b1, 1'b0);
    idle(2);
    n_tests++;
    if (obs() !== mexp()) begin
      n_fail++;
      $display("FAIL parity_err: got %h, expected %h", obs(), mexp());
    end
    read_pulse();
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 1'b0);
    mdl_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(2);
    n_tests++;
    if (obs() !== mexp()) begin
      n_fail++;
      $display("FAIL frame_err: got %h, expected %h", obs(), mexp());
    end
    read_pulse();
    idle(40);
    Serial_In = 1'b1;
    idle(2 * CPB);
    n_tests++;
    if ({obs(), RBusy} !== {mexp(), 1'b0}) begin
      n_fail++;
      $display("FAIL stuck_low_no_frame: got %h, expected %h", {obs(), RBusy}, {mexp(), 1'b0});
    end
    send_frame(8'h55, 1'b0, 1'b1);
    mdl_frame(8'h55, 1'b0, 1'b1, 1'b0);
    idle(2);
    n_tests++;
    if (obs() !== mexp()) begin
      n_fail++;
      $display("FAIL after_stuck_55: got %h, expected %h", obs(), mexp());
    end
    read_pulse();
  endtask

  task automatic test_glitch();
    Serial_In = 1'b0;
    idle(4);
    Serial_In = 1'b1;
    idle(2);
    n_tests++;
    if (RBusy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy: got %b, expected 1", RBusy);
    end
    idle(CPB);
    n_tests++;
    if ({obs(), RBusy} !== {mexp(), 1'b0}) begin
      n_fail++;
      $display("FAIL glitch_rejected: got %h, expected %h", {obs(), RBusy}, {mexp(), 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    int k1;
    int rise;
    k1   = cyc;
    rise = -1;
    fork
      begin
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 400 && rise < 0; i++) begin
          @(posedge Clk);
          #1;
          if (Data_Valid === 1'b1) rise = cyc;
        end
      end
    join
    mdl_frame(8'h11, 1'b0, 1'b1, 1'b0);
    mdl_frame(8'h22, 1'b0, 1'b1, 1'b0);
    idle(2);
    n_tests++;
    if (obs() !== mexp()) begin
      n_fail++;
      $display("FAIL overrun_set: got %h, expected %h", obs(), mexp());
    end
    // Mid-stop on the wire is 10.5 bit periods after the start edge.
    lat = (rise < 0) ? -1 : rise - k1;
    n_tests++;
    if (lat < 10 * CPB + CPB / 2 + SS || lat > 10 * CPB + CPB / 2 + SS + 3) begin
      n_fail++;
      $display("FAIL valid_latency: got %0d cycles, expected %0d..%0d",
               lat, 10 * CPB + CPB / 2 + SS, 10 * CPB + CPB / 2 + SS + 3);
      lat = 10 * CPB + CPB / 2 + SS + 1;
    end
    read_pulse();
    n_tests++;
    if (obs() !== mexp()) begin
      n_fail++;
      $display("FAIL overrun_clear: got %h, expected %h", obs(), mexp());
    end
    // Second round: read lands in the cycle the second frame completes.
    k1 = cyc;
    fork
      begin
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
      end
      begin
        while (cyc < k1 + 11 * CPB + lat - 1) begin
          @(posedge Clk);
          #1;
        end
        Data_Read = 1'b1;
        idle(1);
        Data_Read = 1'b0;
      end
    join
    mdl_frame(8'h11, 1'b0, 1'b1, 1'b0);
    mdl_frame(8'h22, 1'b0, 1'b1, 1'b1);
    idle(2);
    n_tests++;
    if (obs() !== mexp()) begin
      n_fail++;
      $display("FAIL read_on_complete: got %h, expected %h", obs(), mexp());
    end
    read_pulse();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'hF0;
    send_frame(8'h5A, 1'b0, 1'b1);
    mdl_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    Serial_In = d[4];
    idle(8);
    Rst = 1'b0;
    #1;
    mdl_reset();
    n_tests++;
    if ({obs(), RBusy} !== {mexp(), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midframe: got %h, expected %h", {obs(), RBusy}, {mexp(), 1'b0});
    end
    Serial_In = 1'b1;
    idle(3);
    Rst = 1'b1;
    idle(12 * CPB);
    n_tests++;
    if ({obs(), RBusy} !== {mexp(), 1'b0}) begin
      n_fail++;
      $display("FAIL abandoned_frame: got %h, expected %h", {obs(), RBusy}, {mexp(), 1'b0});
    end
    send_frame(8'h0F, 1'b0, 1'b1);
    mdl_frame(8'h0F, 1'b0, 1'b1, 1'b0);
    idle(2);
    n_tests++;
    if (obs() !== mexp()) begin
      n_fail++;
      $display("FAIL after_reset_0f: got %h, expected %h", obs(), mexp());
    end
    read_pulse();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       p, s;
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 4) != 0);
      send_frame(d, p, s);
      Serial_In = 1'b1;
      idle(CPB);
      mdl_frame(d, p, s, 1'b0);
      n_tests++;
      if (obs() !== mexp()) begin
        n_fail++;
        $display("FAIL random_frame_%0d: got %h, expected %h", n, obs(), mexp());
      end
      if ($urandom_range(0, 2) != 0) read_pulse();
    end
    read_pulse();
    n_tests++;
    if (obs() !== mexp()) begin
      n_fail++;
      $display("FAIL random_final_read: got %h, expected %h", obs(), mexp());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
